// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit serializer for the UART 16750 datapath. Takes one parallel
// character from the TX FIFO and shifts it out on SOUT as:
//   start bit (0), 5..8 data bits LSB first, optional parity bit,
//   then 1, 1.5 or 2 stop bits (1).
// Bit timing is derived from CLKEN, a one-CLK-wide pulse at OVERSAMPLE
// times the baud rate. Every bit lasts OVERSAMPLE CLKEN pulses, except the
// 1.5-stop-bit case, which lasts 1.5 * OVERSAMPLE pulses.
//
// Parameters
//   OVERSAMPLE  CLKEN pulses per bit period (even, >= 4)
//
// Ports
//   CLK      in   system clock
//   RST      in   asynchronous reset, active-high
//   CLKEN    in   baud x OVERSAMPLE enable
//   LCR_WLS  in   word length: 00=5, 01=6, 10=7, 11=8 bits
//   LCR_STB  in   0: 1 stop bit; 1: 1.5 (5-bit words) or 2 stop bits
//   LCR_PEN  in   parity enable
//   LCR_EPS  in   even parity select
//   LCR_SP   in   stick parity
//   LCR_BC   in   break control, forces SOUT low while set
//   TXSTART  in   start request, one CLK pulse, honoured only while idle
//   DIN      in   character, DIN[0] is sent first
//   TXBUSY   out  frame in progress
//   TXDONE   out  one-CLK pulse at frame end
//   SOUT     out  serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLKEN,
    input  logic [1:0] LCR_WLS,
    input  logic       LCR_STB,
    input  logic       LCR_PEN,
    input  logic       LCR_EPS,
    input  logic       LCR_SP,
    input  logic       LCR_BC,
    input  logic       TXSTART,
    input  logic [7:0] DIN,
    output logic       TXBUSY,
    output logic       TXDONE,
    output logic       SOUT
);

    // The longest interval the tick counter has to cover is two stop bits.
    localparam int TW = $clog2(2 * OVERSAMPLE);

    // Terminal counts: the counter runs 0..LAST, then the next bit starts.
    localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'((OVERSAMPLE * 3) / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bitIdx_q, bitIdx_d;

    // Frame configuration captured at accept so that LCR/DIN changes during
    // a frame cannot corrupt it.
    logic [7:0]      data_q, data_d;
    logic [1:0]      wls_q, wls_d;
    logic            stb_q, stb_d;
    logic            pen_q, pen_d;
    logic            eps_q, eps_d;
    logic            sp_q, sp_d;

    // Registered outputs.
    logic            txBusy_q, txBusy_d;
    logic            txDone_q, txDone_d;
    logic            sout_q, sout_d;

    // Derived frame values.
    logic [2:0]      lastBitIdx;
    logic [7:0]      dataMask;
    logic [7:0]      dataMasked;
    logic            parityBit;
    logic [TW-1:0]   tickLast;
    logic            tickWrap;
    logic            lineBit;

    // Frame geometry and the parity bit depend only on the latched
    // configuration, so they are stable for the whole frame.
    always_comb begin
        lastBitIdx = 3'({1'b0, wls_q}) + 3'd4;
        dataMask   = 8'hFF >> (2'd3 - wls_q);
        dataMasked = data_q & dataMask;
        if (sp_q) begin
            parityBit = ~eps_q;
        end else if (eps_q) begin
            parityBit = ^dataMasked;
        end else begin
            parityBit = ~^dataMasked;
        end

        // The stop interval is the only one whose length differs from a
        // normal bit; 1.5 stop bits apply only to 5-bit words.
        tickLast = BIT_LAST;
        if (state_q == S_STOP && stb_q) begin
            tickLast = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
        end
        tickWrap = (tick_q == tickLast);
    end

    // Next-state logic. TXSTART is looked at on every CLK while idle, but
    // once a frame is running everything advances only on CLKEN, so a
    // low CLKEN freezes the whole frame in place.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bitIdx_d = bitIdx_q;
        data_d   = data_q;
        wls_d    = wls_q;
        stb_d    = stb_q;
        pen_d    = pen_q;
        eps_d    = eps_q;
        sp_d     = sp_q;
        txDone_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (TXSTART) begin
                    state_d  = S_START;
                    tick_d   = '0;
                    bitIdx_d = 3'd0;
                    data_d   = DIN;
                    wls_d    = LCR_WLS;
                    stb_d    = LCR_STB;
                    pen_d    = LCR_PEN;
                    eps_d    = LCR_EPS;
                    sp_d     = LCR_SP;
                end
            end

            S_START: begin
                if (CLKEN) begin
                    if (tickWrap) begin
                        tick_d   = '0;
                        bitIdx_d = 3'd0;
                        state_d  = S_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_DATA: begin
                if (CLKEN) begin
                    if (tickWrap) begin
                        tick_d = '0;
                        if (bitIdx_q == lastBitIdx) begin
                            bitIdx_d = 3'd0;
                            state_d  = pen_q ? S_PARITY : S_STOP;
                        end else begin
                            bitIdx_d = bitIdx_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (CLKEN) begin
                    if (tickWrap) begin
                        tick_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            S_STOP: begin
                if (CLKEN) begin
                    if (tickWrap) begin
                        tick_d   = '0;
                        state_d  = S_IDLE;
                        txDone_d = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Output values are derived from the next state so that SOUT and
    // TXBUSY change on the same edge as the state register, e.g. the start
    // bit appears on the cycle right after accept. Break is applied after
    // the state decode so the frame keeps its timing underneath it.
    always_comb begin
        lineBit = 1'b1;
        case (state_d)
            S_IDLE:   lineBit = 1'b1;
            S_START:  lineBit = 1'b0;
            S_DATA:   lineBit = data_q[bitIdx_d];
            S_PARITY: lineBit = parityBit;
            S_STOP:   lineBit = 1'b1;
            default:  lineBit = 1'b1;
        endcase

        sout_d   = LCR_BC ? 1'b0 : lineBit;
        txBusy_d = (state_d != S_IDLE);
    end

    // State and output registers. Reset returns the line to idle-high at
    // once and abandons any frame without a TXDONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bitIdx_q <= 3'd0;
            data_q   <= 8'h00;
            wls_q    <= 2'b00;
            stb_q    <= 1'b0;
            pen_q    <= 1'b0;
            eps_q    <= 1'b0;
            sp_q     <= 1'b0;
            txBusy_q <= 1'b0;
            txDone_q <= 1'b0;
            sout_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bitIdx_q <= bitIdx_d;
            data_q   <= data_d;
            wls_q    <= wls_d;
            stb_q    <= stb_d;
            pen_q    <= pen_d;
            eps_q    <= eps_d;
            sp_q     <= sp_d;
            txBusy_q <= txBusy_d;
            txDone_q <= txDone_d;
            sout_q   <= sout_d;
        end
    end

    assign TXBUSY = txBusy_q;
    assign TXDONE = txDone_q;
    assign SOUT   = sout_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Testbench for uart_tx_serializer. The driver sends characters and pushes
// the expected frame (bit list, stop length, total length) built from the
// UART framing rules onto a queue. An independent monitor notices each
// frame start on TXBUSY, pops the expected frame and checks SOUT in the
// middle of every bit, the stop level, the frame length in CLKEN pulses,
// and the TXDONE pulse.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CLKEN;
    logic [1:0] LCR_WLS;
    logic       LCR_STB;
    logic       LCR_PEN;
    logic       LCR_EPS;
    logic       LCR_SP;
    logic       LCR_BC;
    logic       TXSTART;
    logic [7:0] DIN;
    logic       TXBUSY;
    logic       TXDONE;
    logic       SOUT;

    int nCmp = 0;
    int nErr = 0;
    int gcyc = 0;
    int clkenMode = 0;
    int clkenDiv = 0;
    bit bcSampled = 1'b0;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          stopTicks;
        int          T;
        int          expCyc;
        bit          b2b;
    } frame_t;

    frame_t expQ[$];

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .CLKEN   (CLKEN),
        .LCR_WLS (LCR_WLS),
        .LCR_STB (LCR_STB),
        .LCR_PEN (LCR_PEN),
        .LCR_EPS (LCR_EPS),
        .LCR_SP  (LCR_SP),
        .LCR_BC  (LCR_BC),
        .TXSTART (TXSTART),
        .DIN     (DIN),
        .TXBUSY  (TXBUSY),
        .TXDONE  (TXDONE),
        .SOUT    (SOUT)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Cycle counter and the break input as seen by the last active edge.
    always @(posedge CLK) begin
        gcyc      <= gcyc + 1;
        bcSampled <= LCR_BC;
    end

    // CLKEN pattern generator: 0 = always high, 1 = every 4th CLK,
    // 2 = random, 3 = held low.
    initial begin
        CLKEN = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (clkenMode)
                0: CLKEN = 1'b1;
                1: begin
                    CLKEN    = (clkenDiv == 3);
                    clkenDiv = (clkenDiv + 1) % 4;
                end
                2: CLKEN = 1'($urandom_range(0, 1));
                default: CLKEN = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    // Reference frame built from the UART framing rules.
    function automatic frame_t buildFrame(input logic [7:0] din, input logic [1:0] wls,
                                          input logic stb, input logic pen, input logic eps,
                                          input logic sp, input int extraCyc, input bit b2b);
        frame_t f;
        int n;
        int ones;
        n      = 5 + int'(wls);
        ones   = 0;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = din[i];
            ones += int'(din[i]);
        end
        f.nbits = 1 + n;
        if (pen) begin
            if (sp)       f.bits[1 + n] = ~eps;
            else if (eps) f.bits[1 + n] = 1'((ones % 2));
            else          f.bits[1 + n] = 1'(1 - (ones % 2));
            f.nbits++;
        end
        if (!stb)        f.stopTicks = OS;
        else if (n == 5) f.stopTicks = (OS * 3) / 2;
        else             f.stopTicks = 2 * OS;
        f.T      = OS * f.nbits + f.stopTicks;
        f.expCyc = (extraCyc < 0) ? -1 : f.T + extraCyc;
        f.b2b    = b2b;
        return f;
    endfunction

    // Present a character for one CLK, then scramble the inputs so that the
    // frame only passes if the DUT latched them.
    task automatic applyStimulus(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                                 input logic pen, input logic eps, input logic sp,
                                 input int extraCyc, input bit b2b);
        expQ.push_back(buildFrame(din, wls, stb, pen, eps, sp, extraCyc, b2b));
        DIN     = din;
        LCR_WLS = wls;
        LCR_STB = stb;
        LCR_PEN = pen;
        LCR_EPS = eps;
        LCR_SP  = sp;
        TXSTART = 1'b1;
        @(posedge CLK);
        #1;
        TXSTART = 1'b0;
        DIN     = 8'($urandom);
        LCR_WLS = 2'($urandom);
        LCR_STB = 1'($urandom);
        LCR_PEN = 1'($urandom);
        LCR_EPS = 1'($urandom);
        LCR_SP  = 1'($urandom);
    endtask

    // Returns on the negedge where TXDONE is seen.
    task automatic waitDone();
        int c;
        c = 0;
        forever begin
            @(negedge CLK);
            if (TXDONE === 1'b1) break;
            c++;
            if (c > 20000) begin
                nCmp++;
                nErr++;
                $display("[TB] FAIL doneTimeout: got no TXDONE, expected one within 20000 cycles");
                break;
            end
        end
    endtask

    task automatic printSummary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    endtask

    // Monitor: checks every frame the DUT starts against the queue head.
    initial begin : monitor
        bit     prevBusy;
        bit     needDoneLow;
        bit     aborted;
        bit     timedOut;
        bit     stopDone;
        int     lastFall;
        int     t;
        int     cyc;
        int     k;
        frame_t f;
        prevBusy    = 1'b0;
        needDoneLow = 1'b0;
        lastFall    = -10;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1) begin
                prevBusy    = 1'b0;
                needDoneLow = 1'b0;
                continue;
            end
            if (needDoneLow) begin
                checkOutput("doneWidth", 32'(TXDONE), 32'd0);
                needDoneLow = 1'b0;
            end
            if (!prevBusy && TXBUSY === 1'b1) begin
                if (expQ.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("[TB] FAIL unexpectedFrame: got a frame start, expected none");
                    prevBusy = 1'b1;
                    continue;
                end
                f = expQ.pop_front();
                if (f.b2b) checkOutput("b2bGap", 32'(gcyc - lastFall), 32'd1);
                t        = 0;
                cyc      = 0;
                k        = 0;
                aborted  = 1'b0;
                timedOut = 1'b0;
                stopDone = 1'b0;
                forever begin
                    @(posedge CLK);
                    if (CLKEN === 1'b1) t++;
                    cyc++;
                    @(negedge CLK);
                    if (RST === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (TXBUSY !== 1'b1) break;
                    if (k < f.nbits && t == OS * k + OS / 2) begin
                        checkOutput($sformatf("bit%0d", k), 32'(SOUT),
                                    32'(bcSampled ? 1'b0 : f.bits[k]));
                        k++;
                    end
                    if (!stopDone && t == OS * f.nbits + f.stopTicks / 2) begin
                        checkOutput("stopLevel", 32'(SOUT), 32'(bcSampled ? 1'b0 : 1'b1));
                        stopDone = 1'b1;
                    end
                    if (cyc > 20000) begin
                        timedOut = 1'b1;
                        nCmp++;
                        nErr++;
                        $display("[TB] FAIL frameTimeout: got TXBUSY still high, expected frame end within 20000 cycles");
                        break;
                    end
                end
                if (aborted || timedOut) begin
                    prevBusy = 1'b0;
                    continue;
                end
                checkOutput("frameTicks", 32'(t), 32'(f.T));
                checkOutput("bitsSeen", 32'(k), 32'(f.nbits));
                checkOutput("donePulse", 32'(TXDONE), 32'd1);
                if (f.expCyc >= 0) checkOutput("frameCycles", 32'(cyc), 32'(f.expCyc));
                lastFall    = gcyc;
                needDoneLow = 1'b1;
                prevBusy    = 1'b0;
                continue;
            end
            prevBusy = (TXBUSY === 1'b1);
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #3000000;
        nCmp++;
        nErr++;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        printSummary();
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic s;
        int   doneCount;
        RST     = 1'b1;
        TXSTART = 1'b0;
        LCR_BC  = 1'b0;
        LCR_WLS = 2'b11;
        LCR_STB = 1'b0;
        LCR_PEN = 1'b0;
        LCR_EPS = 1'b0;
        LCR_SP  = 1'b0;
        DIN     = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("resetSout", 32'(SOUT), 32'd1);
        checkOutput("resetBusy", 32'(TXBUSY), 32'd0);
        checkOutput("resetDone", 32'(TXDONE), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("idleSout", 32'(SOUT), 32'd1);

        // 8N1 0x55 with CLKEN always high: 160 CLK frame.
        clkenMode = 0;
        applyStimulus(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        waitDone();

        // 7E1 and 7O1 with 0x03.
        repeat (3) @(negedge CLK);
        applyStimulus(8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        waitDone();
        repeat (3) @(negedge CLK);
        applyStimulus(8'h03, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        waitDone();

        // 1.5 and 2 stop bits, stick parity.
        repeat (3) @(negedge CLK);
        applyStimulus(8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        waitDone();
        repeat (3) @(negedge CLK);
        applyStimulus(8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        waitDone();
        repeat (3) @(negedge CLK);
        applyStimulus(8'hB7, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        waitDone();
        repeat (3) @(negedge CLK);
        applyStimulus(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        waitDone();

        // TXSTART mid-frame is ignored; then a back-to-back frame.
        repeat (3) @(negedge CLK);
        applyStimulus(8'h3C, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        repeat (50) @(posedge CLK);
        #1;
        DIN     = 8'hAA;
        TXSTART = 1'b1;
        @(posedge CLK);
        #1;
        TXSTART = 1'b0;
        waitDone();
        applyStimulus(8'hC5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        waitDone();

        // Break while idle.
        repeat (3) @(negedge CLK);
        LCR_BC = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("breakIdle", 32'(SOUT), 32'd0);
        LCR_BC = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("breakIdleRelease", 32'(SOUT), 32'd1);

        // Break during data bits; frame timing must stay nominal.
        repeat (3) @(negedge CLK);
        applyStimulus(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (OS * 3 + 5) @(posedge CLK);
        #1;
        LCR_BC = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("breakOn", 32'(SOUT), 32'd0);
        checkOutput("breakBusy", 32'(TXBUSY), 32'd1);
        repeat (20) @(posedge CLK);
        #1;
        LCR_BC = 1'b0;
        waitDone();

        // Reset in the middle of the data bits.
        repeat (3) @(negedge CLK);
        applyStimulus(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        repeat (OS * 4) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        checkOutput("rstSout", 32'(SOUT), 32'd1);
        checkOutput("rstBusy", 32'(TXBUSY), 32'd0);
        checkOutput("rstDone", 32'(TXDONE), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        doneCount = 0;
        repeat (200) begin
            @(negedge CLK);
            if (TXDONE === 1'b1) doneCount++;
        end
        checkOutput("noDoneAfterRst", 32'(doneCount), 32'd0);

        // CLKEN every 4th CLK.
        @(negedge CLK);
        clkenMode = 1;
        applyStimulus(8'h4D, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        waitDone();

        // CLKEN held low for 40 CLK mid-frame: everything freezes.
        @(negedge CLK);
        clkenMode = 0;
        repeat (3) @(negedge CLK);
        applyStimulus(8'h5A, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 40, 1'b0);
        repeat (OS * 2 + 7) @(posedge CLK);
        @(negedge CLK);
        clkenMode = 3;
        @(negedge CLK);
        @(negedge CLK);
        s = SOUT;
        repeat (38) @(negedge CLK);
        checkOutput("freezeSout", 32'(SOUT), 32'(s));
        checkOutput("freezeBusy", 32'(TXBUSY), 32'd1);
        clkenMode = 0;
        waitDone();

        // Randomized frames, some back-to-back.
        for (int i = 0; i < 20; i++) begin
            int  mode;
            bit  chain;
            chain = (i > 0) && ($urandom_range(0, 2) == 0);
            if (!chain) repeat ($urandom_range(1, 5)) @(negedge CLK);
            mode      = ($urandom_range(0, 1) == 1) ? 0 : 2;
            clkenMode = mode;
            applyStimulus(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), (mode == 0) ? 0 : -1, chain);
            waitDone();
        end

        clkenMode = 0;
        repeat (10) @(negedge CLK);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        printSummary();
        $finish;
    end

endmodule
